// File: rtl/spectrum_equalizer.sv
// Frequency-domain equalizer sitting between a forward and an inverse FFT.
// Each bin is scaled by the gain of the band it falls into. Conjugate bins
// share a band, so the inverse FFT still produces a real-valued signal.
// Two pipeline stages: band/gain lookup, then multiply and saturate.
module spectrum_equalizer #(
    parameter int SAMPLES = 4096,
    parameter int BANDS   = 16
) (
    input  logic                     fft_clk,
    input  logic                     reset_n,
    input  logic                     sink_valid,
    output logic                     sink_ready,
    input  logic [15:0]              sink_real,
    input  logic [15:0]              sink_imag,
    input  logic                     sink_sop,
    input  logic                     sink_eop,
    input  logic [5:0]               sink_exp,
    output logic                     source_valid,
    output logic                     source_sop,
    output logic                     source_eop,
    output logic [15:0]              source_real,
    output logic [15:0]              source_imag,
    output logic [5:0]               source_exp,
    input  logic                     source_ready,
    input  logic                     gain_we,
    input  logic [$clog2(BANDS)-1:0] gain_addr,
    input  logic [7:0]               gain_data,
    input  logic                     bypass,
    output logic                     clip,
    output logic                     frame_err
);

    localparam int K_W       = $clog2(SAMPLES);
    localparam int B_W       = $clog2(BANDS);
    localparam int BIN_SHIFT = $clog2(SAMPLES / (2 * BANDS));
    localparam logic [K_W-1:0] K_LAST = K_W'(SAMPLES - 1);
    localparam logic [7:0]     UNITY  = 8'd128;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic        sop;
        logic        eop;
        logic [5:0]  blk_exp;
    } beat_t;

    // Handshake and framing state
    logic           stall;
    logic           accept;
    logic           in_frame;
    logic           keep;
    logic [K_W-1:0] k_last;
    logic [K_W-1:0] k_cur;
    logic           prev_eop;
    logic           err_sop;
    logic           err_eop;
    logic           err_orphan;

    // Band lookup
    logic [K_W-1:0] fold;
    logic [K_W-1:0] band_full;
    logic [B_W-1:0] band;
    logic [7:0]     staged     [BANDS];
    logic [7:0]     active     [BANDS];
    logic [7:0]     staged_nxt [BANDS];
    logic [7:0]     gain_cur;

    // Pipeline
    beat_t          in_beat;
    beat_t          s1_beat;
    logic           s1_valid;
    logic [7:0]     s1_gain;
    logic           s1_bypass;
    logic [16:0]    res_re;
    logic [16:0]    res_im;
    logic [15:0]    out_re;
    logic [15:0]    out_im;
    logic           out_sat;

    // Signed 16-bit sample times unsigned Q1.7 gain; floor via arithmetic
    // shift, then clamp. Returns {saturated, value}.
    function automatic logic [16:0] scale(input logic [15:0] x, input logic [7:0] g);
        logic signed [24:0] xe;
        logic signed [24:0] ge;
        logic signed [24:0] p;
        xe = 25'($signed(x));
        ge = 25'({1'b0, g});
        p  = (xe * ge) >>> 7;
        if (p > 25'sd32767)
            scale = {1'b1, 16'h7fff};
        else if (p < -25'sd32768)
            scale = {1'b1, 16'h8000};
        else
            scale = {1'b0, p[15:0]};
    endfunction

    // The whole pipe freezes while the output beat is refused downstream.
    assign stall      = source_valid & ~source_ready;
    assign sink_ready = ~stall;
    assign accept     = sink_valid & sink_ready;

    // Beats outside a frame (after eop, before the next sop) are consumed and dropped.
    assign in_frame   = sink_sop | ~prev_eop;
    assign keep       = accept & in_frame;
    assign k_cur      = sink_sop ? '0 : k_last + K_W'(1);

    assign err_sop    = sink_sop & ~prev_eop & (k_last != K_LAST);
    assign err_eop    = sink_eop & (k_cur != K_LAST);
    assign err_orphan = ~sink_sop & prev_eop;

    assign in_beat = '{re: sink_real, im: sink_imag, sop: sink_sop,
                       eop: sink_eop, blk_exp: sink_exp};

    // Fold upper half onto lower half: for k >= SAMPLES/2, -k mod SAMPLES = SAMPLES-k.
    assign fold      = k_cur[K_W-1] ? (~k_cur + K_W'(1)) : k_cur;
    assign band_full = fold >> BIN_SHIFT;
    // Only the Nyquist bin overflows the band range; it joins the top band.
    assign band      = (band_full >= K_W'(BANDS)) ? B_W'(BANDS - 1) : band_full[B_W-1:0];

    // Staged gains with this cycle's write merged in, so a write coinciding with sop counts.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path; a missing
        // branch assignment would infer a latch.
        for (int i = 0; i < BANDS; i++)
            staged_nxt[i] = (gain_we && gain_addr == B_W'(i)) ? gain_data : staged[i];
    end

    // The sop beat already uses the gains it is about to latch into the active bank.
    assign gain_cur = sink_sop ? staged_nxt[band] : active[band];

    // Gain banks: staged follows writes, active is swapped in at frame start.
    always_ff @(posedge fft_clk or negedge reset_n) begin
        // NOTE: the gain banks are a handful of flops with a defined power-up
        // value (unity), so they are reset like any other state; large RAMs
        // would not be.
        if (!reset_n) begin
            for (int i = 0; i < BANDS; i++) begin
                staged[i] <= UNITY;
                active[i] <= UNITY;
            end
        end else begin
            for (int i = 0; i < BANDS; i++) begin
                // NOTE: non-blocking assignment keeps every flop sampling the
                // pre-edge values regardless of statement order.
                staged[i] <= staged_nxt[i];
                if (accept && sink_sop)
                    active[i] <= staged_nxt[i];
            end
        end
    end

    // Bin index, end-of-frame tracking and the sticky framing error.
    always_ff @(posedge fft_clk or negedge reset_n) begin
        if (!reset_n) begin
            k_last    <= '0;
            prev_eop  <= 1'b1;
            frame_err <= 1'b0;
        end else if (accept) begin
            k_last <= k_cur;
            if (in_frame)
                prev_eop <= sink_eop;
            if (err_sop || err_eop || err_orphan)
                frame_err <= 1'b1;
        end
    end

    // Stage 1: capture the beat together with its resolved gain.
    always_ff @(posedge fft_clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_beat   <= '0;
            s1_gain   <= UNITY;
            s1_bypass <= 1'b0;
        end else if (!stall) begin
            s1_valid  <= keep;
            s1_beat   <= in_beat;
            s1_gain   <= gain_cur;
            s1_bypass <= bypass;
        end
    end

    // Scale both components, or pass them straight through in bypass.
    always_comb begin
        res_re = scale(s1_beat.re, s1_gain);
        res_im = scale(s1_beat.im, s1_gain);
        if (s1_bypass) begin
            out_re  = s1_beat.re;
            out_im  = s1_beat.im;
            out_sat = 1'b0;
        end else begin
            out_re  = res_re[15:0];
            out_im  = res_im[15:0];
            out_sat = res_re[16] | res_im[16];
        end
    end

    // Stage 2: source registers; clip fires only on a beat's first presented cycle.
    always_ff @(posedge fft_clk or negedge reset_n) begin
        if (!reset_n) begin
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_real  <= '0;
            source_imag  <= '0;
            source_exp   <= '0;
            clip         <= 1'b0;
        end else if (!stall) begin
            source_valid <= s1_valid;
            source_sop   <= s1_valid & s1_beat.sop;
            source_eop   <= s1_valid & s1_beat.eop;
            source_real  <= out_re;
            source_imag  <= out_im;
            source_exp   <= s1_beat.blk_exp;
            clip         <= s1_valid & out_sat;
        end else begin
            clip <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spectrum_equalizer.sv
// Randomized scoreboard bench for spectrum_equalizer. A driver feeds frames
// and predicts each output beat from a plain arithmetic gain model; a monitor
// pops the predictions and compares them as the DUT presents beats.
module tb_spectrum_equalizer;

    localparam int SAMPLES = 4096;
    localparam int BANDS   = 16;
    localparam int BIN_W   = SAMPLES / (2 * BANDS);

    logic        fft_clk = 1'b0;
    logic        reset_n;
    logic        sink_valid;
    logic        sink_ready;
    logic [15:0] sink_real;
    logic [15:0] sink_imag;
    logic        sink_sop;
    logic        sink_eop;
    logic [5:0]  sink_exp;
    logic        source_valid;
    logic        source_sop;
    logic        source_eop;
    logic [15:0] source_real;
    logic [15:0] source_imag;
    logic [5:0]  source_exp;
    logic        source_ready;
    logic        gain_we;
    logic [3:0]  gain_addr;
    logic [7:0]  gain_data;
    logic        bypass;
    logic        clip;
    logic        frame_err;

    typedef struct {
        int       re;
        int       im;
        bit       sop;
        bit       eop;
        bit [5:0] ex;
        bit       clp;
        int       k;
        int       acc;
        bit       lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model state
    int m_staged [BANDS];
    int m_active [BANDS];
    int m_k;

    // Stimulus control shared with the backpressure process
    bit lat_mode = 1'b0;
    int bp_mode  = 0;
    int hold_cnt = 0;
    int hold_at  = -1;

    // Per-frame input record and captured output, indexed by bin
    int f_re     [SAMPLES];
    int f_im     [SAMPLES];
    int cap_re   [SAMPLES];
    int cap_im   [SAMPLES];
    bit cap_clip [SAMPLES];

    spectrum_equalizer #(.SAMPLES(SAMPLES), .BANDS(BANDS)) dut (
        .fft_clk      (fft_clk),
        .reset_n      (reset_n),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .sink_real    (sink_real),
        .sink_imag    (sink_imag),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_exp     (sink_exp),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_real  (source_real),
        .source_imag  (source_imag),
        .source_exp   (source_exp),
        .source_ready (source_ready),
        .gain_we      (gain_we),
        .gain_addr    (gain_addr),
        .gain_data    (gain_data),
        .bypass       (bypass),
        .clip         (clip),
        .frame_err    (frame_err)
    );

    always #5 fft_clk = ~fft_clk;

    always @(posedge fft_clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int band_of(int k);
        int f;
        int b;
        f = (k < SAMPLES / 2) ? k : SAMPLES - k;
        b = f / BIN_W;
        return (b > BANDS - 1) ? BANDS - 1 : b;
    endfunction

    // x * g / 128 rounded toward negative infinity
    function automatic int floor_q7(int x, int g);
        int p;
        p = x * g;
        if (p >= 0)
            return p / 128;
        return -((-p + 127) / 128);
    endfunction

    function automatic int rnd16();
        case ($urandom_range(7))
            0:       return 32767;
            1:       return -32768;
            default: return int'($urandom_range(65535)) - 32768;
        endcase
    endfunction

    task automatic model_reset();
        for (int b = 0; b < BANDS; b++) begin
            m_staged[b] = 128;
            m_active[b] = 128;
        end
        m_k = 0;
    endtask

    task automatic idle();
        @(negedge fft_clk);
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        gain_we    = 1'b0;
    endtask

    task automatic write_gain(input int a, input int d);
        @(negedge fft_clk);
        sink_valid = 1'b0;
        gain_we    = 1'b1;
        gain_addr  = 4'(a);
        gain_data  = 8'(d);
        #1;
        m_staged[a] = d;
        @(negedge fft_clk);
        gain_we = 1'b0;
    endtask

    // Present one beat until accepted; predict its output at the accepting cycle.
    task automatic send_beat(input int re, input int im, input bit sop, input bit eop,
                             input bit [5:0] ex, input bit byp,
                             input bit we, input int wa, input int wd);
        bit   done;
        int   waited;
        int   g;
        int   p;
        exp_t e;
        done   = 1'b0;
        waited = 0;
        @(negedge fft_clk);
        sink_valid = 1'b1;
        sink_real  = 16'(re);
        sink_imag  = 16'(im);
        sink_sop   = sop;
        sink_eop   = eop;
        sink_exp   = ex;
        bypass     = byp;
        gain_we    = we;
        gain_addr  = 4'(wa);
        gain_data  = 8'(wd);
        #1;
        if (we)
            m_staged[wa] = wd;
        while (!done) begin
            if (sink_ready) begin
                if (sop) begin
                    m_k      = 0;
                    m_active = m_staged;
                end else begin
                    m_k = (m_k + 1) % SAMPLES;
                end
                g     = m_active[band_of(m_k)];
                e.sop = sop;
                e.eop = eop;
                e.ex  = ex;
                e.k   = m_k;
                e.acc = cyc;
                e.lat = lat_mode;
                e.clp = 1'b0;
                if (byp) begin
                    e.re = re;
                    e.im = im;
                end else begin
                    p = floor_q7(re, g);
                    if (p > 32767)  begin p = 32767;  e.clp = 1'b1; end
                    if (p < -32768) begin p = -32768; e.clp = 1'b1; end
                    e.re = p;
                    p = floor_q7(im, g);
                    if (p > 32767)  begin p = 32767;  e.clp = 1'b1; end
                    if (p < -32768) begin p = -32768; e.clp = 1'b1; end
                    e.im = p;
                end
                sb.push_back(e);
                done = 1'b1;
            end else if (waited == 200) begin
                check("sink_ready_wait", sink_ready, 1);
                done = 1'b1;
            end else begin
                @(negedge fft_clk);
                gain_we = 1'b0;
                waited++;
                #1;
            end
        end
    endtask

    // kind 0: ramp real=k, imag=-k; kind 1: random with fixed probes at bins 1 and 2
    task automatic send_frame(input int kind, input bit byp, input int n_beats,
                              input int wr_at, input int wa, input int wd);
        for (int k = 0; k < n_beats; k++) begin
            int re;
            int im;
            if (kind == 0) begin
                re = k;
                im = -k;
            end else begin
                re = rnd16();
                im = rnd16();
                if (k == 1) re = 32767;
                if (k == 2) re = -3;
            end
            f_re[k] = re;
            f_im[k] = im;
            send_beat(re, im, k == 0, k == SAMPLES - 1, 6'($urandom_range(63)), byp,
                      k == wr_at, wa, wd);
            if (k == hold_at)
                hold_cnt = 5;
        end
        idle();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge fft_clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
    endtask

    // Downstream backpressure: directed holds take priority over random mode.
    initial begin : backpressure
        source_ready = 1'b1;
        forever begin
            @(negedge fft_clk);
            if (hold_cnt > 0) begin
                source_ready = 1'b0;
                hold_cnt--;
            end else if (bp_mode == 1) begin
                source_ready = ($urandom_range(3) != 0);
            end else begin
                source_ready = 1'b1;
            end
        end
    end

    // Monitor: check each beat on first presentation and its stability while stalled.
    initial begin : monitor
        exp_t   e;
        bit     fresh;
        bit     held;
        longint held_val;
        longint cur;
        fresh = 1'b1;
        held  = 1'b0;
        forever begin
            @(negedge fft_clk);
            #1;
            if (!reset_n) begin
                fresh = 1'b1;
                held  = 1'b0;
                continue;
            end
            cur = longint'({source_valid, source_sop, source_eop, source_exp,
                            source_real, source_imag});
            if (held)
                check("stall_hold_stable", cur, held_val);
            if (source_valid) begin
                if (fresh) begin
                    if (sb.size() == 0) begin
                        check("unexpected_beat_valid", source_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("k%0d_data", e.k),
                              longint'({source_sop, source_eop, source_exp, source_real, source_imag}),
                              longint'({e.sop, e.eop, e.ex, 16'(e.re), 16'(e.im)}));
                        check($sformatf("k%0d_clip", e.k), clip, e.clp);
                        if (e.lat)
                            check($sformatf("k%0d_latency", e.k), cyc - e.acc, 2);
                        cap_re[e.k]   = $signed(source_real);
                        cap_im[e.k]   = $signed(source_imag);
                        cap_clip[e.k] = clip;
                    end
                end else begin
                    check("clip_during_stall", clip, 0);
                end
                if (source_ready) begin
                    fresh = 1'b1;
                    held  = 1'b0;
                end else begin
                    fresh    = 1'b0;
                    held     = 1'b1;
                    held_val = cur;
                    check("sink_ready_in_stall", sink_ready, 0);
                end
            end else begin
                fresh = 1'b1;
                held  = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        reset_n    = 1'b0;
        sink_valid = 1'b0;
        sink_real  = '0;
        sink_imag  = '0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        sink_exp   = '0;
        gain_we    = 1'b0;
        gain_addr  = '0;
        gain_data  = '0;
        bypass     = 1'b0;
        model_reset();
        #1;
        check("reset_state",
              longint'({source_valid, source_sop, source_eop, clip, frame_err,
                        source_exp, source_real, source_imag, ~sink_ready}), 0);
        repeat (3) @(negedge fft_clk);
        reset_n = 1'b1;

        // Unity ramp frame with exact latency
        lat_mode = 1'b1;
        send_frame(0, 1'b0, SAMPLES, -1, 0, 0);
        wait_drain();
        lat_mode = 1'b0;
        check("ramp_last_real", cap_re[SAMPLES-1], SAMPLES - 1);
        check("ramp_frame_err", frame_err, 0);

        // Heavy gain on band 0 under random backpressure
        write_gain(0, 255);
        for (int b = 1; b < BANDS; b++)
            write_gain(b, $urandom_range(255));
        bp_mode = 1;
        send_frame(1, 1'b0, SAMPLES, -1, 0, 0);
        wait_drain();
        bp_mode = 0;
        check("gain255_bin1_real", cap_re[1], 32767);
        check("gain255_bin1_clip", cap_clip[1], 1);

        // Half gain on band 0, plus a 5-cycle downstream hold mid-frame
        write_gain(0, 64);
        hold_at = 2000;
        send_frame(1, 1'b0, SAMPLES, -1, 0, 0);
        hold_at = -1;
        wait_drain();
        check("gain64_bin2_real", cap_re[2], -2);

        // Only the top band muted
        for (int b = 0; b < BANDS; b++)
            write_gain(b, (b == 15) ? 0 : 128);
        send_frame(1, 1'b0, SAMPLES, -1, 0, 0);
        wait_drain();
        check("band15_bin1919_real", cap_re[1919], f_re[1919]);
        check("band15_bin1919_imag", cap_im[1919], f_im[1919]);
        check("band15_bin2177_real", cap_re[2177], f_re[2177]);
        for (int k = 1920; k <= 2176; k += 64) begin
            check($sformatf("band15_bin%0d_real", k), cap_re[k], 0);
            check($sformatf("band15_bin%0d_imag", k), cap_im[k], 0);
        end

        // Mid-frame write to band 3 must not affect the running frame
        send_frame(1, 1'b0, SAMPLES, 1000, 3, 0);
        wait_drain();
        check("midwrite_bin400_real", cap_re[400], f_re[400]);
        check("midwrite_bin3600_imag", cap_im[3600], f_im[3600]);

        // Next frame picks up band 3 = 0; a write on the sop cycle is also live
        send_frame(1, 1'b0, SAMPLES, 0, 7, 200);
        wait_drain();
        for (int k = 384; k <= 511; k += 127)
            check($sformatf("band3_bin%0d_real", k), cap_re[k], 0);
        for (int k = 3585; k <= 3712; k += 127)
            check($sformatf("band3_bin%0d_imag", k), cap_im[k], 0);

        // Bypass with arbitrary gains: unchanged data, no clip
        for (int b = 0; b < BANDS; b++)
            write_gain(b, $urandom_range(255));
        send_frame(1, 1'b1, SAMPLES, -1, 0, 0);
        wait_drain();
        check("bypass_bin1_real", cap_re[1], 32767);
        check("bypass_bin1_clip", cap_clip[1], 0);
        check("clean_frames_frame_err", frame_err, 0);

        // Premature sop at k=100
        send_frame(1, 1'b0, 100, -1, 0, 0);
        send_frame(1, 1'b0, SAMPLES, -1, 0, 0);
        wait_drain();
        check("early_sop_frame_err", frame_err, 1);

        // Reset in the middle of a frame
        send_frame(1, 1'b0, 500, -1, 0, 0);
        @(negedge fft_clk);
        reset_n    = 1'b0;
        sink_valid = 1'b0;
        sb.delete();
        model_reset();
        #1;
        check("midframe_reset_state",
              longint'({source_valid, source_sop, source_eop, clip, frame_err,
                        source_exp, source_real, source_imag, ~sink_ready}), 0);
        repeat (2) @(negedge fft_clk);
        reset_n = 1'b1;

        // Clean frame after reset, random gains and backpressure
        for (int b = 0; b < BANDS; b += 3)
            write_gain(b, $urandom_range(255));
        bp_mode = 1;
        send_frame(1, 1'b0, SAMPLES, -1, 0, 0);
        wait_drain();
        bp_mode = 0;
        check("post_reset_frame_err", frame_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
